// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, one-entry registered output with valid/ready, redirect flush; ecall halt when IFU_HALT_DETECT_EN is defined.
// One instruction per cycle; PC and output hold while out_valid && !out_ready; redirect flushes any pending output.
module instruction_fetch #(
  parameter logic [9:0] RESET_PC = 10'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  read_addr,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [9:0]  redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [9:0]  out_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  logic [9:0]  pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [9:0]  out_pc_q, out_pc_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        run;
  logic        load;

`ifdef IFU_HALT_DETECT_EN
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t state_q, state_d;
  logic   halted_q, halted_d;

  assign run    = (state_q == ST_RUN);
  assign halted = halted_q;
`else
  assign run    = 1'b1;
  assign halted = 1'b0;
`endif

  assign load = !redirect_valid && run && (!out_valid_q || out_ready);

  always_comb begin
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fetch_count_d = fetch_count_q;
`ifdef IFU_HALT_DETECT_EN
    state_d       = state_q;
    halted_d      = halted_q;
`endif
    if (redirect_valid) begin
      // Redirect wins over everything, including a pending unaccepted output.
      pc_d        = redirect_addr;
      out_valid_d = 1'b0;
`ifdef IFU_HALT_DETECT_EN
      state_d     = ST_RUN;
      halted_d    = 1'b0;
`endif
    end else if (load) begin
      out_instr_d = instruction;
      out_pc_d    = pc_q;
      out_valid_d = 1'b1;
      pc_d        = pc_q + 10'd1;
      if (fetch_count_q != 16'hFFFF) begin
        fetch_count_d = fetch_count_q + 16'd1;
      end
`ifdef IFU_HALT_DETECT_EN
      // The ecall itself is presented; PC stays on it so a later reset/redirect decides where to go.
      if (instruction == ECALL) begin
        pc_d     = pc_q;
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'd0;
      out_pc_q      <= 10'd0;
      fetch_count_q <= 16'd0;
`ifdef IFU_HALT_DETECT_EN
      state_q       <= ST_RUN;
      halted_q      <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
`ifdef IFU_HALT_DETECT_EN
      state_q       <= state_d;
      halted_q      <= halted_d;
`endif
    end
  end

  assign read_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 10'd0, giving the word address fetched first after reset.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port read_addr  output  10  word address driven to the instruction memory; equals the internal PC.
REQ-005 The block SHALL have port instruction  input  32  instruction word returned combinationally by the memory for read_addr in the same cycle.
REQ-006 The block SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 The block SHALL have port redirect_addr  input  10  redirect target word address.
REQ-008 The block SHALL have port out_valid  output  1  registered instruction available to decode.
REQ-009 The block SHALL have port out_ready  input  1  decode accepts out_instr this cycle.
REQ-010 The block SHALL have port out_instr  output  32  registered fetched instruction.
REQ-011 The block SHALL have port out_pc  output  10  word address of out_instr.
REQ-012 The block SHALL have port halted  output  1  fetch stopped on halt instruction.
REQ-013 The block SHALL have port fetch_count  output  16  number of instructions loaded into the output register.

Function
REQ-014 read_addr SHALL equal PC combinationally.
REQ-015 The load condition SHALL be: state RUN, no redirect_valid, and (out_valid==0 or out_ready==1).
REQ-016 On load: out_instr<=instruction, out_pc<=PC, out_valid<=1, PC<=PC+1, fetch_count<=fetch_count+1.
REQ-017 Handshake: transfer occurs when out_valid and out_ready are both 1; while out_valid=1 and out_ready=0, out_instr, out_pc, out_valid and PC SHALL hold.
REQ-018 When no load occurs and out_ready=1, out_valid SHALL go to 0.
REQ-019 Throughput SHALL be one instruction per cycle while out_ready is held at 1.
REQ-020 PC SHALL wrap 1023 -> 0 with no flag.
REQ-021 redirect_valid SHALL have priority over load, stall and halt: PC<=redirect_addr, out_valid<=0, state<=RUN, halted<=0.
REQ-022 Redirect latency: redirect asserted at edge N gives read_addr=redirect_addr after N; the target instruction appears with out_valid=1 after edge N+1.
REQ-023 A redirect concurrent with a pending unaccepted output SHALL discard that output.
REQ-024 fetch_count SHALL saturate at 16'hFFFF.
REQ-025 The states SHALL be RUN and HALT; HALT is reachable only per REQ-029.

Reset
REQ-026 While reset is high, asynchronously: PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0, state=RUN.
REQ-027 The first load SHALL occur on the first rising edge after reset deasserts; reset mid-stall SHALL drop the pending output.

Configuration
REQ-028 Halt detection SHALL be compiled in by macro IFU_HALT_DETECT_EN.
REQ-029 With the macro defined, a load of instruction==32'h00000073 (ecall) SHALL present it normally, leave PC unchanged, set state=HALT and halted=1, and perform no further loads until a redirect or reset.
REQ-030 Without the macro, 32'h00000073 SHALL be fetched as an ordinary instruction, halted SHALL be tied to 0, and no HALT state SHALL exist.

Verification
REQ-031 Stream: memory words 0..5 preset, out_ready=1 -> out_pc 0,1,2,3,4,5 on consecutive cycles; fetch_count=6.
REQ-032 Stall: out_ready=0 for 3 cycles while out_pc=2 -> out_instr/out_pc/read_addr held at word 2 / PC 3; resumes with pc 3 on the next cycle.
REQ-033 Redirect: redirect_valid with redirect_addr=10'd40 while stalled -> out_valid=0 next cycle, then out_pc=40.
REQ-034 Wrap: redirect to 1022 -> out_pc sequence 1022, 1023, 0.
REQ-035 Halt (macro on): ecall at word 3 -> out_pc=3 valid, halted=1, no further outputs; redirect to 0 clears halted. Macro off: fetch continues with out_pc=4.
REQ-036 Reset asserted mid-stream -> all outputs 0 immediately and read_addr=RESET_PC; fetch restarts at RESET_PC.
